// File: rtl/instr_fetch_unit.sv
// Instruction-fetch initiator: drives word addresses to a combinational instruction
// memory, buffers {pc, instruction} in a first-word-fall-through prefetch FIFO and
// hands entries to decode over a valid/ready handshake. A redirect flushes the FIFO
// and restarts fetch at a new, word-aligned target.
// Optional feature macro: FETCH_ALIGN_CHECK_EN adds the misalign flag for redirects
// whose target has nonzero low address bits.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic [31:0]                   Dir,
    input  logic [31:0]                   Inst_mem,
    input  logic                          redirect,
    input  logic [31:0]                   redirect_pc,
    output logic                          inst_valid,
    input  logic                          inst_ready,
    output logic [31:0]                   inst,
    output logic [31:0]                   inst_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic                          misalign
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic {
        S_BOOT,
        S_FETCH
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop, full;

    logic [31:0]   pc_buf  [FIFO_DEPTH];
    logic [31:0]   ins_buf [FIFO_DEPTH];

    assign full       = (count == DEPTH_C);
    assign inst_valid = (count != '0);
    assign pop        = inst_valid & inst_ready;
    assign Dir        = fetch_pc;
    assign fifo_count = count;
    assign inst       = inst_valid ? ins_buf[rd_ptr] : 32'h0;
    assign inst_pc    = inst_valid ? pc_buf[rd_ptr]  : 32'h0;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        unique case (state_q)
            S_BOOT:  state_d = S_FETCH;
            S_FETCH: push    = !full || pop;
            default: state_d = S_BOOT;
        endcase
        // Redirect wins over everything: the flushed FIFO takes no new entry this cycle.
        if (redirect) begin
            state_d = S_FETCH;
            push    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_BOOT;
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state_q <= state_d;
            if (redirect) begin
                fetch_pc <= redirect_pc & ~32'h3;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    wr_ptr   <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    // NOTE: the entry storage is deliberately not reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_buf[wr_ptr]  <= fetch_pc;
            ins_buf[wr_ptr] <= Inst_mem;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign <= 1'b0;
        end else begin
            misalign <= redirect && (redirect_pc[1:0] != 2'b00);
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory model returns word index (mem[i] = i),
// outputs are sampled on the falling edge, inputs driven on the falling edge.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] Dir;
    logic [31:0] Inst_mem;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [2:0]  fifo_count;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int total = 0;
    int bad   = 0;

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Dir         (Dir),
        .Inst_mem    (Inst_mem),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .fifo_count  (fifo_count)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .misalign    (misalign)
`endif
    );

    // Combinational memory: word i holds value i.
    assign Inst_mem = {2'b00, Dir[31:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b1;

        // Reset state
        repeat (2) tick();
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_count", {29'b0, fifo_count}, 32'd0);
        check("rst_dir",   Dir,     32'h0);
        check("rst_inst",  inst,    32'h0);
        check("rst_pc",    inst_pc, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        check("rst_misalign", {31'b0, misalign}, 32'd0);
`endif

        // Streaming fetch with decode always ready
        rst = 1'b0;
        tick();
        check("boot_valid", {31'b0, inst_valid}, 32'd0);
        check("boot_dir",   Dir, 32'h0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("stream_valid", {31'b0, inst_valid}, 32'd1);
            check("stream_pc",    inst_pc, 32'(4 * k));
            check("stream_inst",  inst,    32'(k));
            check("stream_count", {29'b0, fifo_count}, 32'd1);
            check("stream_dir",   Dir, 32'(4 * k + 4));
        end

        // Back-pressure from reset: FIFO saturates, head and Dir hold
        rst        = 1'b1;
        inst_ready = 1'b0;
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check("fill_count", {29'b0, fifo_count}, (e < 2) ? 32'd0 : ((e - 1 > 4) ? 32'd4 : 32'(e - 1)));
        end
        check("full_dir",  Dir,     32'h10);
        check("full_pc",   inst_pc, 32'h0);
        check("full_inst", inst,    32'h0);

        // Release: push and pop every cycle at full occupancy, no gaps or repeats
        inst_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check("drain_pc",    inst_pc, 32'(4 * k));
            check("drain_count", {29'b0, fifo_count}, 32'd4);
            tick();
        end
        check("drain_dir", Dir, 32'h30);

        // Redirect while full flushes stale entries
        inst_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        check("flush_count", {29'b0, fifo_count}, 32'd0);
        check("flush_valid", {31'b0, inst_valid}, 32'd0);
        check("flush_pc",    inst_pc, 32'h0);
        check("flush_dir",   Dir, 32'h40);
        redirect   = 1'b0;
        inst_ready = 1'b1;
        tick();
        check("redir_valid", {31'b0, inst_valid}, 32'd1);
        check("redir_pc",    inst_pc, 32'h40);
        check("redir_inst",  inst,    32'h10);
        tick();
        check("redir_pc2",   inst_pc, 32'h44);

        // Unaligned target (head valid and popped in the same cycle)
        redirect    = 1'b1;
        redirect_pc = 32'h22;
        tick();
        check("align_dir",   Dir, 32'h20);
        check("align_count", {29'b0, fifo_count}, 32'd0);
`ifdef FETCH_ALIGN_CHECK_EN
        check("misalign_hi", {31'b0, misalign}, 32'd1);
`endif
        redirect = 1'b0;
        tick();
        check("align_pc",   inst_pc, 32'h20);
        check("align_inst", inst,    32'h8);
`ifdef FETCH_ALIGN_CHECK_EN
        check("misalign_lo", {31'b0, misalign}, 32'd0);
`endif
        tick();
        check("align_pc2", inst_pc, 32'h24);

        // Address wrap at the top of the space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        check("wrap_dir", Dir, 32'hFFFF_FFF8);
        redirect = 1'b0;
        tick();
        check("wrap_pc0",   inst_pc, 32'hFFFF_FFF8);
        check("wrap_inst0", inst,    32'h3FFF_FFFE);
        tick();
        check("wrap_pc1",   inst_pc, 32'hFFFF_FFFC);
        check("wrap_inst1", inst,    32'h3FFF_FFFF);
        tick();
        check("wrap_pc2",   inst_pc, 32'h0);
        check("wrap_inst2", inst,    32'h0);

        // Asynchronous reset mid-stream with three entries held
        inst_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        repeat (3) tick();
        check("pre_rst_count", {29'b0, fifo_count}, 32'd3);
        check("pre_rst_pc",    inst_pc, 32'h100);
        rst = 1'b1;
        #1;
        check("async_valid", {31'b0, inst_valid}, 32'd0);
        check("async_count", {29'b0, fifo_count}, 32'd0);
        check("async_inst",  inst,    32'h0);
        check("async_pc",    inst_pc, 32'h0);
        check("async_dir",   Dir,     32'h0);
        @(negedge clk);
        rst        = 1'b0;
        inst_ready = 1'b1;
        tick();
        check("restart_boot", {31'b0, inst_valid}, 32'd0);
        tick();
        check("restart_valid", {31'b0, inst_valid}, 32'd1);
        check("restart_pc",    inst_pc, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
